// File: rtl/matrix_addr_gen_pkg.sv
// rtl/matrix_addr_gen_pkg.sv - shared state encoding and default sizes for the matrix address generator
package matrix_addr_gen_pkg;

  localparam int DEF_AW  = 16;
  localparam int DEF_NCH = 8;
  localparam int DEF_CW  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_e;

endpackage

// File: rtl/addr_gen_channel.sv
// rtl/addr_gen_channel.sv - one channel: walk FSM, column/row counters and address register
module addr_gen_channel
  import matrix_addr_gen_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] start_addr_i,
  input  logic [AW-1:0] stride_i,
  input  logic [CW-1:0] ncols_i,
  input  logic [CW-1:0] nrows_i,
  output logic [AW-1:0] addr_o,
  output logic          valid_o,
  output logic          done_o
);

  chan_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] row_start_q, row_start_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] ncols_q, ncols_d;
  logic [CW-1:0] nrows_q, nrows_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_start_d = row_start_q;
    stride_d    = stride_q;
    col_d       = col_q;
    row_d       = row_q;
    ncols_d     = ncols_q;
    nrows_d     = nrows_q;
    // load takes priority over step so a restart never advances on its first cycle
    if (load_i) begin
      addr_d      = start_addr_i;
      row_start_d = start_addr_i;
      stride_d    = stride_i;
      col_d       = '0;
      row_d       = '0;
      ncols_d     = ncols_i;
      nrows_d     = nrows_i;
      state_d     = (ncols_i == '0 || nrows_i == '0) ? DONE : RUN;
    end else if (step_i && state_q == RUN) begin
      if (col_q < ncols_q - CW'(1)) begin
        col_d  = col_q + CW'(1);
        addr_d = addr_q + AW'(1);
      end else if (row_q < nrows_q - CW'(1)) begin
        col_d       = '0;
        row_d       = row_q + CW'(1);
        row_start_d = row_start_q + stride_q;
        addr_d      = row_start_q + stride_q;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      row_start_q <= '0;
      stride_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ncols_q     <= '0;
      nrows_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_start_q <= row_start_d;
      stride_q    <= stride_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ncols_q     <= ncols_d;
      nrows_q     <= nrows_d;
    end
  end

  assign addr_o  = addr_q;
  assign valid_o = (state_q == RUN);
  assign done_o  = (state_q == DONE);

endmodule

// File: rtl/matrix_addr_gen.sv
// rtl/matrix_addr_gen.sv - NCH independent 2-D tile address walkers, one per core
module matrix_addr_gen
  import matrix_addr_gen_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [AW-1:0]     base_in,
  input  logic [AW-1:0]     ch_off_in,
  input  logic [AW-1:0]     stride_in,
  input  logic [CW-1:0]     ncols_in,
  input  logic [CW-1:0]     nrows_in,
  output logic [NCH*AW-1:0] addr_out,
  output logic [NCH-1:0]    valid_out,
  output logic [NCH-1:0]    done_out,
  output logic              busy_out
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [AW-1:0] start_addr;

    // channel g starts g offsets past the tile base, wrapping modulo 2^AW
    assign start_addr = base_in + AW'(g) * ch_off_in;

    addr_gen_channel #(
      .AW (AW),
      .CW (CW)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load & ch_mask[g]),
      .step_i       (step & ch_mask[g]),
      .start_addr_i (start_addr),
      .stride_i     (stride_in),
      .ncols_i      (ncols_in),
      .nrows_i      (nrows_in),
      .addr_o       (addr_out[g*AW +: AW]),
      .valid_o      (valid_out[g]),
      .done_o       (done_out[g])
    );
  end

  assign busy_out = |valid_out;

endmodule

// File: tb/tb_matrix_addr_gen.sv
// tb/tb_matrix_addr_gen.sv - self-checking bench for matrix_addr_gen with a tile-index reference model
module tb_matrix_addr_gen;

  logic         clk = 1'b0;
  logic         rst, load, step;
  logic [7:0]   ch_mask;
  logic [15:0]  base_in, ch_off_in, stride_in;
  logic [7:0]   ncols_in, nrows_in;
  logic [127:0] addr_out;
  logic [7:0]   valid_out, done_out;
  logic         busy_out;

  int n_vec  = 0;
  int n_fail = 0;
  bit en_cmp = 0;

  // model: each channel is a start address plus a linear element index into its tile
  int          m_st    [8];
  int          m_k     [8];
  int          m_start [8];
  int          m_stride[8];
  int          m_nc    [8];
  int          m_nr    [8];
  logic [15:0] m_addr  [8];

  always #5 clk = ~clk;

  matrix_addr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .ch_mask   (ch_mask),
    .base_in   (base_in),
    .ch_off_in (ch_off_in),
    .stride_in (stride_in),
    .ncols_in  (ncols_in),
    .nrows_in  (nrows_in),
    .addr_out  (addr_out),
    .valid_out (valid_out),
    .done_out  (done_out),
    .busy_out  (busy_out)
  );

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_st[i] = 0; m_k[i] = 0; m_start[i] = 0; m_stride[i] = 0;
      m_nc[i] = 0; m_nr[i] = 0; m_addr[i] = '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) begin
        m_st[i]   = 0;
        m_k[i]    = 0;
        m_addr[i] = '0;
      end else if (load && ch_mask[i]) begin
        m_start[i]  = (int'(base_in) + i * int'(ch_off_in)) & 'hFFFF;
        m_stride[i] = int'(stride_in);
        m_nc[i]     = int'(ncols_in);
        m_nr[i]     = int'(nrows_in);
        m_k[i]      = 0;
        m_addr[i]   = 16'(m_start[i]);
        m_st[i]     = (m_nc[i] == 0 || m_nr[i] == 0) ? 2 : 1;
      end else if (step && ch_mask[i] && m_st[i] == 1) begin
        if (m_k[i] + 1 == m_nc[i] * m_nr[i]) begin
          m_st[i] = 2;
        end else begin
          m_k[i]    = m_k[i] + 1;
          m_addr[i] = 16'(m_start[i] + (m_k[i] / m_nc[i]) * m_stride[i] + (m_k[i] % m_nc[i]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      logic [127:0] e_addr;
      logic [7:0]   e_valid, e_done;
      for (int i = 0; i < 8; i++) begin
        e_addr[i*16 +: 16] = m_addr[i];
        e_valid[i]         = (m_st[i] == 1);
        e_done[i]          = (m_st[i] == 2);
      end
      n_vec++;
      if (addr_out !== e_addr || valid_out !== e_valid || done_out !== e_done ||
          busy_out !== (|e_valid)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t addr=%h exp=%h valid=%h exp=%h done=%h exp=%h busy=%b exp=%b",
                 $time, addr_out, e_addr, valid_out, e_valid, done_out, e_done, busy_out, |e_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] b, o, s, input logic [7:0] nc, nr);
    base_in = b; ch_off_in = o; stride_in = s; ncols_in = nc; nrows_in = nr;
  endtask

  task automatic cyc(input logic r, ld, st, input logic [7:0] m);
    rst = r; load = ld; step = st; ch_mask = m;
    @(negedge clk);
    rst = 1'b0; load = 1'b0; step = 1'b0;
  endtask

  function automatic logic [15:0] ch_addr(input int ch);
    return addr_out[ch*16 +: 16];
  endfunction

  logic [15:0] walk_exp [6];

  initial begin
    walk_exp = '{16'h0000, 16'h0001, 16'h0002, 16'h0010, 16'h0011, 16'h0012};
    rst = 1'b1; load = 1'b0; step = 1'b0; ch_mask = '0;
    cfg(16'h0, 16'h0, 16'h0, 8'd0, 8'd0);
    @(posedge clk);
    en_cmp = 1;
    cyc(1, 0, 0, 8'h00);
    chk("reset_addr", addr_out, '0);
    chk("reset_flags", {valid_out, done_out, 7'd0, busy_out}, '0);

    // load fan-out
    cfg(16'h1000, 16'h0100, 16'h0040, 8'd4, 8'd4);
    cyc(0, 1, 0, 8'hFF);
    chk("fanout_ch0", ch_addr(0), 16'h1000);
    chk("fanout_ch3", ch_addr(3), 16'h1300);
    chk("fanout_ch7", ch_addr(7), 16'h1700);
    chk("fanout_valid", valid_out, 8'hFF);

    // reset mid-walk overrides load and step
    cyc(0, 0, 1, 8'hFF);
    chk("midwalk_ch1", ch_addr(1), 16'h1101);
    cyc(1, 1, 1, 8'hFF);
    chk("midreset_addr", addr_out, '0);
    chk("midreset_flags", {valid_out, done_out, 7'd0, busy_out}, '0);

    // 2-D walk on ch0; config changes between loads must be ignored
    cfg(16'h0000, 16'h0000, 16'h0010, 8'd3, 8'd2);
    cyc(0, 1, 0, 8'h01);
    chk("walk_0", ch_addr(0), walk_exp[0]);
    for (int s = 1; s < 6; s++) begin
      cfg(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      cyc(0, 0, 1, 8'h01);
      chk($sformatf("walk_%0d", s), ch_addr(0), walk_exp[s]);
    end
    cyc(0, 0, 1, 8'h01);
    chk("walk_done_flags", {valid_out[0], done_out[0]}, 2'b01);
    chk("walk_done_addr", ch_addr(0), 16'h0012);
    cyc(0, 0, 1, 8'h01);
    chk("step_after_done", {ch_addr(0), valid_out[0], done_out[0]}, {16'h0012, 2'b01});

    // mask and load/step collision
    cfg(16'h1000, 16'h0100, 16'h0040, 8'd4, 8'd4);
    cyc(0, 1, 0, 8'hFF);
    cyc(0, 0, 1, 8'hFF);
    cyc(0, 0, 1, 8'hFF);
    cyc(0, 1, 1, 8'h05);
    chk("collide_ch2", ch_addr(2), 16'h1200);
    chk("collide_ch1", ch_addr(1), 16'h1102);
    cyc(0, 0, 1, 8'h01);
    chk("mask_ch0", ch_addr(0), 16'h1001);
    chk("mask_ch2", ch_addr(2), 16'h1200);

    // zero dimensions finish at once
    cfg(16'h0500, 16'h0000, 16'h0000, 8'd0, 8'd3);
    cyc(0, 1, 0, 8'h01);
    chk("ncols0_flags", {valid_out[0], done_out[0]}, 2'b01);
    cfg(16'h0500, 16'h0000, 16'h0000, 8'd3, 8'd0);
    cyc(0, 1, 0, 8'h02);
    chk("nrows0_flags", {valid_out[1], done_out[1]}, 2'b01);

    // address wrap
    cfg(16'hFFFF, 16'h0000, 16'h0000, 8'd2, 8'd1);
    cyc(0, 1, 0, 8'h01);
    cyc(0, 0, 1, 8'h01);
    chk("wrap_addr", {ch_addr(0), valid_out[0]}, {16'h0000, 1'b1});
    cyc(0, 0, 1, 8'h01);
    chk("wrap_done", {ch_addr(0), done_out[0]}, {16'h0000, 1'b1});

    // reload from DONE
    cfg(16'h2000, 16'h0000, 16'h0000, 8'd2, 8'd2);
    cyc(0, 1, 0, 8'h01);
    chk("reload", {ch_addr(0), valid_out[0], done_out[0]}, {16'h2000, 2'b10});

    // row wrap across the top of the address space on several channels
    cfg(16'hFFF0, 16'h0004, 16'h0020, 8'd2, 8'd2);
    cyc(0, 1, 0, 8'hAA);
    cyc(0, 0, 1, 8'hAA);
    cyc(0, 0, 1, 8'hAA);
    chk("rowwrap_ch1", ch_addr(1), 16'h0014);

    for (int n = 0; n < 60; n++) begin
      cfg(16'($urandom), 16'($urandom), 16'($urandom),
          8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 5) == 0),
          $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
